// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Single write port scheduler for the 32x32 register file. It
//            picks one of three writeback sources each cycle (ALU, load,
//            JAL link) in round-robin order and registers the winning
//            address/data toward the register file. It also provides
//            bypass-hit flags and a saturating contention counter.
// Ports    :
//   clk, reset                 clock, synchronous active-high reset
//   stall                      blocks all grants while high
//   alu_valid/rw/data/ready    ALU writeback handshake (ready combinational)
//   mem_valid/rw/data/ready    load writeback handshake (ready combinational)
//   lnk_valid/pc/ready         link handshake, writes {pc,2'b00} to r31
//   regwr, rw, busw            registered register-file write port
//   ra, rb / byp_a, byp_b      read addresses and in-flight write hit flags
//   contention                 saturating count of multi-request cycles
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rw,
  input  logic [31:0]   alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [4:0]    mem_rw,
  input  logic [31:0]   mem_data,
  output logic          mem_ready,
  input  logic          lnk_valid,
  input  logic [29:0]   lnk_pc,
  output logic          lnk_ready,
  output logic          regwr,
  output logic [4:0]    rw,
  output logic [31:0]   busw,
  input  logic [4:0]    ra,
  input  logic [4:0]    rb,
  output logic          byp_a,
  output logic          byp_b,
  output logic [CW-1:0] contention
);

  localparam logic [1:0] c_SRC_ALU = 2'd0;
  localparam logic [1:0] c_SRC_MEM = 2'd1;
  localparam logic [1:0] c_SRC_LNK = 2'd2;
  localparam logic [4:0] c_LINK_REG = 5'd31;

  // Successor in the 3-entry ring; the unused code 3 folds back to alu.
  function automatic logic [1:0] next3(input logic [1:0] x);
    next3 = (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  logic [1:0]    r_rr;
  logic [3:0]    w_valid;
  logic [1:0]    w_c0, w_c1, w_c2;
  logic          w_gnt;
  logic [1:0]    w_idx;
  logic [4:0]    w_addr;
  logic [31:0]   w_data;
  logic          w_multi;
  logic          r_regwr;
  logic [4:0]    r_rw;
  logic [31:0]   r_busw;
  logic [CW-1:0] r_cnt;

  // Bit 3 pads the vector so any 2-bit index is in range.
  assign w_valid = {1'b0, lnk_valid, mem_valid, alu_valid};

  // Candidate order starting at the round-robin pointer.
  assign w_c0 = (r_rr == 2'd3) ? 2'd0 : r_rr;
  assign w_c1 = next3(w_c0);
  assign w_c2 = next3(w_c1);

  always_comb begin
    w_gnt = 1'b0;
    w_idx = c_SRC_ALU;
    if (!reset && !stall) begin
      if (w_valid[w_c0]) begin
        w_gnt = 1'b1;
        w_idx = w_c0;
      end else if (w_valid[w_c1]) begin
        w_gnt = 1'b1;
        w_idx = w_c1;
      end else if (w_valid[w_c2]) begin
        w_gnt = 1'b1;
        w_idx = w_c2;
      end
    end
  end

  assign alu_ready = w_gnt && (w_idx == c_SRC_ALU);
  assign mem_ready = w_gnt && (w_idx == c_SRC_MEM);
  assign lnk_ready = w_gnt && (w_idx == c_SRC_LNK);

  always_comb begin
    w_addr = alu_rw;
    w_data = alu_data;
    case (w_idx)
      c_SRC_MEM: begin
        w_addr = mem_rw;
        w_data = mem_data;
      end
      c_SRC_LNK: begin
        w_addr = c_LINK_REG;
        w_data = {lnk_pc, 2'b00};
      end
      default: begin
        w_addr = alu_rw;
        w_data = alu_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= c_SRC_ALU;
    end else if (w_gnt) begin
      r_rr <= next3(w_idx);
    end
  end

  // A grant to r0 is consumed and still loads rw/busw, but never writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwr <= 1'b0;
      r_rw    <= 5'd0;
      r_busw  <= 32'd0;
    end else if (w_gnt) begin
      r_regwr <= (w_addr != 5'd0);
      r_rw    <= w_addr;
      r_busw  <= w_data;
    end else begin
      r_regwr <= 1'b0;
    end
  end

  // Contention is counted from the raw requests, independent of stall.
  assign w_multi = (alu_valid && mem_valid) || (alu_valid && lnk_valid) ||
                   (mem_valid && lnk_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_multi && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign regwr      = r_regwr;
  assign rw         = r_rw;
  assign busw       = r_busw;
  assign contention = r_cnt;

  assign byp_a = r_regwr && (r_rw == ra) && (ra != 5'd0);
  assign byp_b = r_regwr && (r_rw == rb) && (rb != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter. Expected writes are
//            queued by the stimulus; a monitor pops them whenever regwr is
//            seen. A second instance with CW=2 checks counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic        alu_valid, mem_valid, lnk_valid;
  logic [4:0]  alu_rw, mem_rw;
  logic [31:0] alu_data, mem_data;
  logic [29:0] lnk_pc;
  logic [4:0]  ra, rb;
  logic        alu_ready, mem_ready, lnk_ready;
  logic        regwr, byp_a, byp_b;
  logic [4:0]  rw;
  logic [31:0] busw;
  logic [7:0]  contention;

  logic        alu_ready2, mem_ready2, lnk_ready2;
  logic        regwr2, byp_a2, byp_b2;
  logic [4:0]  rw2;
  logic [31:0] busw2;
  logic [1:0]  contention2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.CW(8)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .alu_valid(alu_valid), .alu_rw(alu_rw), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_data(mem_data), .mem_ready(mem_ready),
    .lnk_valid(lnk_valid), .lnk_pc(lnk_pc), .lnk_ready(lnk_ready),
    .regwr(regwr), .rw(rw), .busw(busw),
    .ra(ra), .rb(rb), .byp_a(byp_a), .byp_b(byp_b),
    .contention(contention)
  );

  regfile_wb_arbiter #(.CW(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall),
    .alu_valid(alu_valid), .alu_rw(alu_rw), .alu_data(alu_data), .alu_ready(alu_ready2),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_data(mem_data), .mem_ready(mem_ready2),
    .lnk_valid(lnk_valid), .lnk_pc(lnk_pc), .lnk_ready(lnk_ready2),
    .regwr(regwr2), .rw(rw2), .busw(busw2),
    .ra(ra), .rb(rb), .byp_a(byp_a2), .byp_b(byp_b2),
    .contention(contention2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Readies as a 3-bit vector {lnk,mem,alu}.
  task automatic chk_rdy(input string nm, input logic [2:0] exp);
    chk(nm, {29'd0, lnk_ready, mem_ready, alu_ready}, {29'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    lnk_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every observed write must match the oldest expected.
  always @(negedge clk) begin
    if (regwr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rw=%0d busw=%h, expected no write", rw, busw);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("write_port", {rw, busw}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] order [3];
    reset = 1'b1; stall = 1'b0; idle();
    alu_rw = 5'd0; alu_data = 32'd0; mem_rw = 5'd0; mem_data = 32'd0;
    lnk_pc = 30'd0; ra = 5'd0; rb = 5'd0;

    // Reset state, with a request pending across the reset cycle.
    tick();
    alu_valid = 1'b1; alu_rw = 5'd5; alu_data = 32'h1234;
    #1;
    chk_rdy("ready_in_reset", 3'b000);
    tick();
    chk("reset_regwr", {31'd0, regwr}, 32'd0);
    chk("reset_rw", {27'd0, rw}, 32'd0);
    chk("reset_busw", busw, 32'd0);
    chk("reset_contention", {24'd0, contention}, 32'd0);
    reset = 1'b0;
    #1;
    chk_rdy("single_alu_ready", 3'b001);
    exp_q.push_back({5'd5, 32'h1234});
    tick();
    idle();
    chk("single_alu_regwr", {31'd0, regwr}, 32'd1);
    tick();
    chk("single_alu_regwr_drop", {31'd0, regwr}, 32'd0);

    // All three continuously valid from reset: alu, mem, lnk, alu, ...
    reset = 1'b1;
    alu_valid = 1'b1; alu_rw = 5'd3; alu_data = 32'hA3;
    mem_valid = 1'b1; mem_rw = 5'd4; mem_data = 32'hB4;
    lnk_valid = 1'b1; lnk_pc = 30'h100;
    tick();
    reset = 1'b0;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk_rdy("rr_order", order[i % 3]);
      chk("contention_count", {24'd0, contention}, i);
      case (i % 3)
        0: exp_q.push_back({5'd3, 32'hA3});
        1: exp_q.push_back({5'd4, 32'hB4});
        default: exp_q.push_back({5'd31, 32'h400});
      endcase
      tick();
    end
    idle();
    chk("contention_after6", {24'd0, contention}, 32'd6);

    // Write to r0 via mem: consumed, no regwr, rr moves to lnk.
    tick();
    do_reset();
    mem_valid = 1'b1; mem_rw = 5'd0; mem_data = 32'hDEAD;
    #1;
    chk_rdy("r0_mem_ready", 3'b010);
    tick();
    idle();
    chk("r0_regwr", {31'd0, regwr}, 32'd0);
    chk("r0_rw", {27'd0, rw}, 32'd0);
    chk("r0_busw", busw, 32'hDEAD);
    alu_valid = 1'b1; alu_rw = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rw = 5'd2; mem_data = 32'h22;
    lnk_valid = 1'b1; lnk_pc = 30'h5;
    #1;
    chk_rdy("after_r0_lnk_first", 3'b100);
    exp_q.push_back({5'd31, 32'h14});
    tick();
    lnk_valid = 1'b0;
    #1;
    chk_rdy("after_r0_alu_second", 3'b001);
    exp_q.push_back({5'd1, 32'h11});
    tick();
    alu_valid = 1'b0;
    #1;
    chk_rdy("after_r0_mem_third", 3'b010);
    exp_q.push_back({5'd2, 32'h22});
    tick();
    idle();

    // Stall blocks grants for 3 cycles; grant right after release.
    tick();
    do_reset();
    stall = 1'b1;
    alu_valid = 1'b1; alu_rw = 5'd9; alu_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rdy("stall_ready", 3'b000);
      tick();
      chk("stall_regwr", {31'd0, regwr}, 32'd0);
    end
    stall = 1'b0;
    #1;
    chk_rdy("post_stall_ready", 3'b001);
    exp_q.push_back({5'd9, 32'h99});
    tick();
    idle();

    // Bypass flags.
    tick();
    alu_valid = 1'b1; alu_rw = 5'd7; alu_data = 32'h77;
    exp_q.push_back({5'd7, 32'h77});
    tick();
    idle();
    ra = 5'd7; rb = 5'd0;
    #1;
    chk("byp_a_hit", {31'd0, byp_a}, 32'd1);
    chk("byp_b_zero", {31'd0, byp_b}, 32'd0);
    rb = 5'd7; ra = 5'd6;
    #1;
    chk("byp_b_hit", {31'd0, byp_b}, 32'd1);
    chk("byp_a_miss", {31'd0, byp_a}, 32'd0);
    alu_valid = 1'b1; alu_rw = 5'd0; alu_data = 32'h55;
    tick();
    idle();
    ra = 5'd0; rb = 5'd0;
    #1;
    chk("byp_a_r0", {31'd0, byp_a}, 32'd0);
    chk("r0_alu_busw", busw, 32'h55);

    // Saturation of the CW=2 counter; counting continues through stall.
    tick();
    do_reset();
    stall = 1'b1;
    alu_valid = 1'b1; alu_rw = 5'd10; alu_data = 32'hAA;
    mem_valid = 1'b1; mem_rw = 5'd11; mem_data = 32'hBB;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_contention_cw2", {30'd0, contention2}, 32'd3);
    chk("contention_cw8_5", {24'd0, contention}, 32'd5);
    tick();
    chk("sat_contention_hold", {30'd0, contention2}, 32'd3);

    // Reset mid-stream: outputs cleared, alu first afterwards.
    stall = 1'b0;
    lnk_valid = 1'b1; lnk_pc = 30'h7;
    do_reset();
    #1;
    chk_rdy("pre_mid_reset_alu", 3'b001);
    exp_q.push_back({5'd10, 32'hAA});
    tick();
    alu_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_rdy("mid_reset_ready", 3'b000);
    tick();
    chk("mid_reset_regwr", {31'd0, regwr}, 32'd0);
    chk("mid_reset_rw", {27'd0, rw}, 32'd0);
    chk("mid_reset_busw", busw, 32'd0);
    chk("mid_reset_contention", {24'd0, contention}, 32'd0);
    reset = 1'b0;
    alu_valid = 1'b1; alu_rw = 5'd12; alu_data = 32'hCC;
    #1;
    chk_rdy("post_reset_alu_first", 3'b001);
    exp_q.push_back({5'd12, 32'hCC});
    tick();
    idle();
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
